// File: rtl/multi_cycle_cu_pkg.sv
// Shared types for the multi-cycle control unit:
// opcodes, state codes, mux/alu codes, control bundle.
package multi_cycle_cu_pkg;

  localparam int OP_W    = 3;
  localparam int STATE_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_JUMP  = 3'd2,
    OP_BZ    = 3'd3,
    OP_CTYPE = 3'd4,
    OP_ADDI  = 3'd5,
    OP_SUBI  = 3'd6,
    OP_ANDI  = 3'd7
  } opcode_e;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_LD_RD  = 4'd2,
    S_LD_WB  = 4'd3,
    S_ST     = 4'd4,
    S_JMP    = 4'd5,
    S_BZ     = 4'd6,
    S_C_EX   = 4'd7,
    S_C_WB   = 4'd8,
    S_I_EX   = 4'd9,
    S_I_WB   = 4'd10
  } state_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_FUNC = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  localparam logic [1:0] PC_ALU = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  function automatic logic [2:0] imm_alu_op(
    input logic [OP_W-1:0] op
  );
    logic [2:0] r;
    r = ALU_ADD;
    unique case (1'b1)
      (op == OP_SUBI): r = ALU_SUB;
      (op == OP_ANDI): r = ALU_AND;
      default:         r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multi_cycle_cu_out_decode.sv
// Combinational decode of the current state (plus
// opcode, mem_ready, notnoop) into the control bundle.
module multi_cycle_cu_out_decode
  import multi_cycle_cu_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  input  logic               notnoop,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_LD_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_LD_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_ST: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_JMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_JMP;
      end
      S_BZ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_BR;
      end
      S_C_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNC;
      end
      S_C_WB: begin
        ctrl.alu_op    = ALU_FUNC;
        ctrl.reg_write = notnoop;
      end
      S_I_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_alu_op(opcode);
      end
      S_I_WB: begin
        ctrl.alu_op    = imm_alu_op(opcode);
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_cu.sv
// Main control FSM: state register, next-state logic,
// and reset gating of the decoded control outputs.
module multi_cycle_cu
  import multi_cycle_cu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               notnoop,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  ctrl_t              dec;
  ctrl_t              ctrl;

  // zero qualifies pc_write_cond outside this block
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LOAD:  state_d = S_LD_RD;
          OP_STORE: state_d = S_ST;
          OP_JUMP:  state_d = S_JMP;
          OP_BZ:    state_d = S_BZ;
          OP_CTYPE: state_d = S_C_EX;
          default:  state_d = S_I_EX;
        endcase
      end
      S_LD_RD: if (mem_ready) state_d = S_LD_WB;
      S_ST:    if (mem_ready) state_d = S_FETCH;
      S_C_EX:  state_d = S_C_WB;
      S_I_EX:  state_d = S_I_WB;
      default: state_d = S_FETCH;
    endcase
  end

  multi_cycle_cu_out_decode u_dec (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .notnoop   (notnoop),
    .ctrl      (dec)
  );

  // state_q already sits in FETCH during reset; mask its strobes
  always_comb begin
    ctrl = dec;
    if (!rst) ctrl = '0;
  end

  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign i_or_d        = ctrl.i_or_d;
  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_src        = ctrl.pc_src;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign state         = state_q;

endmodule

// File: tb/tb_multi_cycle_cu.sv
// Directed bench for multi_cycle_cu: walks each
// instruction class, waits, resets and a stray state.
module tb_multi_cycle_cu;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       notnoop;
  logic       mem_read, mem_write, i_or_d, ir_write;
  logic       pc_write, pc_write_cond, alu_src_a;
  logic       mem_to_reg, reg_write;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic [15:0] outs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_cycle_cu dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .notnoop       (notnoop),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .state         (state)
  );

  assign outs = {mem_read, mem_write, i_or_d, ir_write,
                 pc_write, pc_write_cond, pc_src,
                 alu_src_a, alu_src_b, alu_op,
                 mem_to_reg, reg_write};

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    opcode = 3'd0;
    zero = 1'b0;
    mem_ready = 1'b0;
    notnoop = 1'b0;
    step();
    step();
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_outs", outs, 16'h0000);

    rst = 1'b1;
    #1;
    chk("fetch_state", 16'(state), 16'd0);
    chk("fetch_rd", 16'(mem_read), 16'd1);
    chk("fetch_srcb", 16'(alu_src_b), 16'd1);
    chk("fetch_irw_wait", 16'(ir_write), 16'd0);

    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_state", 16'(state), 16'd0);
      chk("wait_rd", 16'(mem_read), 16'd1);
      chk("wait_irpc", 16'({ir_write, pc_write}), 16'd0);
    end
    mem_ready = 1'b1;
    #1;
    chk("fetch_irpc", 16'({ir_write, pc_write}), 16'd3);

    step();
    chk("ld_dec", 16'(state), 16'd1);
    chk("dec_outs", outs, 16'h0000);
    step();
    chk("ld_rd", 16'(state), 16'd2);
    chk("ld_rd_rdid", 16'({mem_read, i_or_d}), 16'd3);
    chk("ld_rd_rw", 16'(reg_write), 16'd0);
    step();
    chk("ld_wb", 16'(state), 16'd3);
    chk("ld_wb_rw", 16'({reg_write, mem_to_reg}), 16'd3);
    step();
    chk("ld_done", 16'(state), 16'd0);
    chk("ld_done_rw", 16'({reg_write, mem_to_reg}), 16'd0);

    step();
    step();
    mem_ready = 1'b0;
    step();
    chk("ld_hold", 16'(state), 16'd2);
    chk("ld_hold_rd", 16'(mem_read), 16'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 16'(state), 16'd0);
    chk("mid_rst_rd", 16'(mem_read), 16'd0);
    step();
    chk("mid_rst_outs", outs, 16'h0000);
    rst = 1'b1;
    #1;
    chk("post_rst_state", 16'(state), 16'd0);
    chk("post_rst_rd", 16'(mem_read), 16'd1);

    opcode = 3'd4;
    mem_ready = 1'b1;
    notnoop = 1'b0;
    step();
    step();
    chk("c_ex", 16'(state), 16'd7);
    chk("c_ex_alu", 16'({alu_src_a, alu_src_b, alu_op}),
        16'b1_00_010);
    step();
    chk("c_wb", 16'(state), 16'd8);
    chk("c_wb_nop", 16'({reg_write, alu_op}), 16'b0_010);
    notnoop = 1'b1;
    #1;
    chk("c_wb_op", 16'({reg_write, alu_op}), 16'b1_010);
    step();
    chk("c_done", 16'(state), 16'd0);

    opcode = 3'd3;
    step();
    step();
    chk("bz", 16'(state), 16'd6);
    chk("bz_outs", outs, 16'b0000_0101_1000_0100);
    step();
    chk("bz_done", 16'(state), 16'd0);

    opcode = 3'd6;
    step();
    step();
    chk("subi_ex", 16'(state), 16'd9);
    chk("subi_ex_alu", 16'({alu_src_a, alu_src_b, alu_op}),
        16'b1_10_001);
    step();
    chk("subi_wb", 16'({state, reg_write, alu_op}),
        16'b1010_1_001);
    step();

    opcode = 3'd7;
    step();
    step();
    chk("andi_ex", 16'({state, alu_op}), 16'b1001_011);
    step();
    step();

    opcode = 3'd5;
    step();
    step();
    chk("addi_ex", 16'({state, alu_op, alu_src_b}),
        16'b1001_000_10);
    step();
    step();

    opcode = 3'd2;
    step();
    step();
    chk("jmp", 16'(state), 16'd5);
    chk("jmp_outs", outs, 16'b0000_1010_0000_0000);
    step();
    chk("jmp_done", 16'(state), 16'd0);

    opcode = 3'd1;
    step();
    mem_ready = 1'b0;
    step();
    chk("st", 16'(state), 16'd4);
    chk("st_wrid", 16'({mem_write, i_or_d, mem_read}), 16'b110);
    step();
    chk("st_hold", 16'({state, mem_write}), 16'b0100_1);
    mem_ready = 1'b1;
    step();
    chk("st_done", 16'(state), 16'd0);

    mem_ready = 1'b0;
    force dut.state_q = 4'd13;
    #1;
    chk("bad_state", 16'(state), 16'd13);
    chk("bad_outs", outs, 16'h0000);
    release dut.state_q;
    step();
    chk("bad_recover", 16'(state), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
